// File: rtl/ex_mem_pkg.sv
// Shared constants for the EX/MEM stage: opcodes, ALU flag indices, control bit indices.
package ex_mem_pkg;

   localparam int unsigned OPW = 3;
   localparam int unsigned NF  = 5;
   localparam int unsigned NC  = 3;

   localparam logic [OPW-1:0] OP_ADDU = 3'b000;
   localparam logic [OPW-1:0] OP_ADDS = 3'b001;
   localparam logic [OPW-1:0] OP_AND  = 3'b010;
   localparam logic [OPW-1:0] OP_OR   = 3'b011;
   localparam logic [OPW-1:0] OP_SLT  = 3'b100;
   localparam logic [OPW-1:0] OP_BNE  = 3'b101;

   // Flag vector is {Cout, V, lt, eq, gt}
   localparam int unsigned F_GT   = 0;
   localparam int unsigned F_EQ   = 1;
   localparam int unsigned F_LT   = 2;
   localparam int unsigned F_V    = 3;
   localparam int unsigned F_COUT = 4;

   // Control vector is {reg_write, mem_read, mem_write}
   localparam int unsigned C_MW = 0;
   localparam int unsigned C_MR = 1;
   localparam int unsigned C_RW = 2;

endpackage

// File: rtl/ex_exc_ctrl.sv
// Sticky signed-overflow exception: exc_ovf/epc registers, capture blocking, set-over-clear.
module ex_exc_ctrl
   import ex_mem_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ex_valid,
   input  logic [OPW-1:0] ex_opcod,
   input  logic           ex_v,
   input  logic [W-1:0]   ex_pc,
   input  logic           flush,
   input  logic           mem_stall,
   input  logic           exc_clr,
   output logic           exc_ovf,
   output logic [W-1:0]   epc,
   output logic           blocked_c,
   output logic           trap_c
);

   logic set_c;

   assign blocked_c = exc_ovf | flush;
   assign trap_c    = ex_valid & (ex_opcod == OP_ADDS) & ex_v & ~blocked_c;
   // A trap only lands when its instruction is actually captured.
   assign set_c     = trap_c & ~mem_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exc_ovf <= 1'b0;
         epc     <= W'(0);
      end else if (set_c) begin
         exc_ovf <= 1'b1;
         epc     <= ex_pc;
      end else if (exc_clr) begin
         exc_ovf <= 1'b0;
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with bne resolution, overflow trap and EX->EX forwarding bus.
module ex_mem_stage
   import ex_mem_pkg::*;
#(
   parameter int unsigned W  = 16,
   parameter int unsigned RA = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ex_valid,
   input  logic [OPW-1:0] ex_opcod,
   input  logic [W-1:0]   ex_alu_out,
   input  logic [NF-1:0]  ex_flags,
   input  logic [W-1:0]   ex_store_data,
   input  logic [RA-1:0]  ex_rd,
   input  logic [NC-1:0]  ex_ctrl,
   input  logic           ex_branch,
   input  logic [W-1:0]   ex_br_target,
   input  logic [W-1:0]   ex_pc,
   input  logic           mem_stall,
   input  logic           flush,
   input  logic           exc_clr,
   output logic           mem_valid,
   output logic [W-1:0]   mem_alu_out,
   output logic [W-1:0]   mem_store_data,
   output logic [RA-1:0]  mem_rd,
   output logic [NC-1:0]  mem_ctrl,
   output logic [NF-1:0]  status_flags,
   output logic           br_taken,
   output logic [W-1:0]   br_target,
   output logic           exc_ovf,
   output logic [W-1:0]   epc,
   output logic           fwd_en,
   output logic [RA-1:0]  fwd_rd,
   output logic [W-1:0]   fwd_data
);

   logic          blocked_c;
   logic          trap_c;
   logic          cap_c;
   logic          take_c;
   logic          load_c;
   logic          unused_op_c;
   logic [NC-1:0] ctrl_next_c;
   logic [W-1:0]  alu_next_c;

   ex_exc_ctrl #(.W(W)) u_exc (
      .clk       (clk),
      .rst_n     (rst_n),
      .ex_valid  (ex_valid),
      .ex_opcod  (ex_opcod),
      .ex_v      (ex_flags[F_V]),
      .ex_pc     (ex_pc),
      .flush     (flush),
      .mem_stall (mem_stall),
      .exc_clr   (exc_clr),
      .exc_ovf   (exc_ovf),
      .epc       (epc),
      .blocked_c (blocked_c),
      .trap_c    (trap_c)
   );

   assign cap_c       = ex_valid & ~blocked_c;
   assign take_c      = cap_c & ex_branch & (ex_opcod == OP_BNE) & ~ex_flags[F_EQ];
   // Flush overrides stall: a flushed edge always loads a bubble.
   assign load_c      = flush | ~mem_stall;
   assign unused_op_c = (ex_opcod[2:1] == 2'b11);

   always_comb begin
      ctrl_next_c = ex_ctrl;
      alu_next_c  = ex_alu_out;
      if (unused_op_c) alu_next_c = W'(0);
      if (!cap_c || (ex_opcod == OP_BNE) || unused_op_c || trap_c) ctrl_next_c = NC'(0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_valid      <= 1'b0;
         mem_alu_out    <= W'(0);
         mem_store_data <= W'(0);
         mem_rd         <= RA'(0);
         mem_ctrl       <= NC'(0);
         status_flags   <= NF'(0);
         br_taken       <= 1'b0;
         br_target      <= W'(0);
      end else begin
         // Pulse is dropped under stall so a held branch never re-fires.
         br_taken <= take_c & ~mem_stall;
         if (load_c) begin
            mem_valid      <= cap_c;
            mem_alu_out    <= alu_next_c;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
            mem_ctrl       <= ctrl_next_c;
            if (cap_c)  status_flags <= ex_flags;
            if (take_c) br_target    <= ex_br_target;
         end
      end
   end

   assign fwd_en   = mem_valid & mem_ctrl[C_RW];
   assign fwd_rd   = mem_rd;
   assign fwd_data = mem_alu_out;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage.
module tb_ex_mem_stage;

   localparam int unsigned W  = 16;
   localparam int unsigned RA = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ex_valid;
   logic [2:0]    ex_opcod;
   logic [W-1:0]  ex_alu_out;
   logic [4:0]    ex_flags;
   logic [W-1:0]  ex_store_data;
   logic [RA-1:0] ex_rd;
   logic [2:0]    ex_ctrl;
   logic          ex_branch;
   logic [W-1:0]  ex_br_target;
   logic [W-1:0]  ex_pc;
   logic          mem_stall;
   logic          flush;
   logic          exc_clr;
   logic          mem_valid;
   logic [W-1:0]  mem_alu_out;
   logic [W-1:0]  mem_store_data;
   logic [RA-1:0] mem_rd;
   logic [2:0]    mem_ctrl;
   logic [4:0]    status_flags;
   logic          br_taken;
   logic [W-1:0]  br_target;
   logic          exc_ovf;
   logic [W-1:0]  epc;
   logic          fwd_en;
   logic [RA-1:0] fwd_rd;
   logic [W-1:0]  fwd_data;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   ex_mem_stage #(.W(W), .RA(RA)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcod(ex_opcod),
      .ex_alu_out(ex_alu_out), .ex_flags(ex_flags), .ex_store_data(ex_store_data),
      .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_branch(ex_branch),
      .ex_br_target(ex_br_target), .ex_pc(ex_pc), .mem_stall(mem_stall),
      .flush(flush), .exc_clr(exc_clr), .mem_valid(mem_valid),
      .mem_alu_out(mem_alu_out), .mem_store_data(mem_store_data), .mem_rd(mem_rd),
      .mem_ctrl(mem_ctrl), .status_flags(status_flags), .br_taken(br_taken),
      .br_target(br_target), .exc_ovf(exc_ovf), .epc(epc), .fwd_en(fwd_en),
      .fwd_rd(fwd_rd), .fwd_data(fwd_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ins(input logic v, input logic [2:0] op, input logic [W-1:0] alu,
                      input logic [4:0] fl, input logic [RA-1:0] rd, input logic [2:0] ctl,
                      input logic br, input logic [W-1:0] tgt, input logic [W-1:0] pc);
      ex_valid      = v;
      ex_opcod      = op;
      ex_alu_out    = alu;
      ex_flags      = fl;
      ex_store_data = 16'hBEEF;
      ex_rd         = rd;
      ex_ctrl       = ctl;
      ex_branch     = br;
      ex_br_target  = tgt;
      ex_pc         = pc;
   endtask

   initial begin
      rst_n = 1'b0; mem_stall = 1'b0; flush = 1'b0; exc_clr = 1'b0;
      ins(1'b0, 3'b000, 16'h0, 5'b0, 3'd0, 3'b000, 1'b0, 16'h0, 16'h0);
      #12;
      chk("rst_valid", 32'(mem_valid), 32'd0);
      chk("rst_alu", 32'(mem_alu_out), 32'd0);
      chk("rst_ctrl", 32'(mem_ctrl), 32'd0);
      chk("rst_flags", 32'(status_flags), 32'd0);
      chk("rst_br", 32'({br_taken, br_target}), 32'd0);
      chk("rst_exc", 32'({exc_ovf, epc}), 32'd0);
      chk("rst_fwd", 32'(fwd_en), 32'd0);
      rst_n = 1'b1;
      step();

      // addu 3+4 -> rd 2, reg_write
      ins(1'b1, 3'b000, 16'h0007, 5'b00001, 3'd2, 3'b100, 1'b0, 16'h0, 16'h0002);
      step();
      chk("addu_valid", 32'(mem_valid), 32'd1);
      chk("addu_alu", 32'(mem_alu_out), 32'h7);
      chk("addu_fwd_en", 32'(fwd_en), 32'd1);
      chk("addu_fwd_rd", 32'(fwd_rd), 32'd2);
      chk("addu_fwd_data", 32'(fwd_data), 32'h7);
      chk("addu_ctrl", 32'(mem_ctrl), 32'b100);
      chk("addu_sd", 32'(mem_store_data), 32'hBEEF);
      chk("addu_flags", 32'(status_flags), 32'b00001);

      // bne taken
      ins(1'b1, 3'b101, 16'h0001, 5'b00100, 3'd1, 3'b100, 1'b1, 16'h0040, 16'h0004);
      step();
      chk("bne_taken", 32'(br_taken), 32'd1);
      chk("bne_target", 32'(br_target), 32'h40);
      chk("bne_ctrl", 32'(mem_ctrl), 32'd0);
      chk("bne_valid", 32'(mem_valid), 32'd1);
      ins(1'b0, 3'b000, 16'h0, 5'b0, 3'd0, 3'b000, 1'b0, 16'h0, 16'h0);
      step();
      chk("bne_pulse_end", 32'(br_taken), 32'd0);
      chk("idle_valid", 32'(mem_valid), 32'd0);

      // bne with eq=1 not taken
      ins(1'b1, 3'b101, 16'h0000, 5'b00010, 3'd1, 3'b100, 1'b1, 16'h0080, 16'h0006);
      step();
      chk("bne_eq_not_taken", 32'(br_taken), 32'd0);
      chk("bne_eq_target_held", 32'(br_target), 32'h40);

      // unused opcode 110
      ins(1'b1, 3'b110, 16'h1234, 5'b00000, 3'd3, 3'b110, 1'b0, 16'h0, 16'h0008);
      step();
      chk("op110_alu", 32'(mem_alu_out), 32'd0);
      chk("op110_ctrl", 32'(mem_ctrl), 32'd0);
      chk("op110_valid", 32'(mem_valid), 32'd1);

      // addu with V=1 does not trap
      ins(1'b1, 3'b000, 16'h8000, 5'b01000, 3'd3, 3'b100, 1'b0, 16'h0, 16'h0010);
      step();
      chk("addu_v_no_trap", 32'(exc_ovf), 32'd0);
      chk("addu_v_ctrl", 32'(mem_ctrl), 32'b100);

      // signed add 0x7FFF+1 traps
      ins(1'b1, 3'b001, 16'h8000, 5'b01000, 3'd4, 3'b100, 1'b0, 16'h0, 16'h0012);
      step();
      chk("trap_exc", 32'(exc_ovf), 32'd1);
      chk("trap_epc", 32'(epc), 32'h12);
      chk("trap_ctrl", 32'(mem_ctrl), 32'd0);
      chk("trap_valid", 32'(mem_valid), 32'd1);
      chk("trap_flags", 32'(status_flags), 32'b01000);

      for (int i = 0; i < 3; i++) begin
         ins(1'b1, 3'b000, 16'h0005, 5'b00001, 3'd5, 3'b100, 1'b0, 16'h0, 16'h0014);
         step();
         chk("blocked_valid", 32'(mem_valid), 32'd0);
         chk("blocked_ctrl", 32'(mem_ctrl), 32'd0);
      end
      chk("blocked_flags_held", 32'(status_flags), 32'b01000);

      // exc_clr: the instruction on the clearing edge is still blocked
      exc_clr = 1'b1;
      ins(1'b1, 3'b000, 16'h0009, 5'b00001, 3'd6, 3'b100, 1'b0, 16'h0, 16'h0016);
      step();
      exc_clr = 1'b0;
      chk("clr_exc", 32'(exc_ovf), 32'd0);
      chk("clr_edge_bubble", 32'(mem_valid), 32'd0);
      step();
      chk("after_clr_valid", 32'(mem_valid), 32'd1);
      chk("after_clr_alu", 32'(mem_alu_out), 32'h9);
      chk("after_clr_fwd", 32'(fwd_en), 32'd1);

      // branch captured, then three stalled cycles
      ins(1'b1, 3'b101, 16'h0002, 5'b00000, 3'd1, 3'b000, 1'b1, 16'h0044, 16'h0018);
      step();
      chk("stall_pre_taken", 32'(br_taken), 32'd1);
      mem_stall = 1'b1;
      ins(1'b1, 3'b000, 16'h0033, 5'b00001, 3'd7, 3'b100, 1'b0, 16'h0, 16'h001A);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_br", 32'(br_taken), 32'd0);
         chk("stall_alu", 32'(mem_alu_out), 32'h2);
         chk("stall_ctrl_valid", 32'({mem_valid, mem_ctrl}), 32'b1000);
      end
      mem_stall = 1'b0;
      step();
      chk("unstall_alu", 32'(mem_alu_out), 32'h33);
      chk("unstall_rd_ctrl", 32'({mem_rd, mem_ctrl}), 32'b111100);

      // flush beats stall
      mem_stall = 1'b1; flush = 1'b1;
      ins(1'b1, 3'b000, 16'h0044, 5'b00001, 3'd2, 3'b100, 1'b0, 16'h0, 16'h001C);
      step();
      chk("flush_stall_valid", 32'(mem_valid), 32'd0);
      chk("flush_stall_ctrl", 32'(mem_ctrl), 32'd0);
      mem_stall = 1'b0;

      // flush suppresses a trap
      ins(1'b1, 3'b001, 16'h8000, 5'b01000, 3'd2, 3'b100, 1'b0, 16'h0, 16'h0020);
      step();
      flush = 1'b0;
      chk("flush_no_trap", 32'(exc_ovf), 32'd0);
      chk("flush_trap_valid", 32'(mem_valid), 32'd0);

      // exc_clr coinciding with a trap: set wins
      exc_clr = 1'b1;
      ins(1'b1, 3'b001, 16'h8000, 5'b01000, 3'd2, 3'b100, 1'b0, 16'h0, 16'h0022);
      step();
      exc_clr = 1'b0;
      chk("set_over_clr", 32'(exc_ovf), 32'd1);
      chk("set_over_clr_epc", 32'(epc), 32'h22);

      // exc_clr honoured during stall
      mem_stall = 1'b1; exc_clr = 1'b1;
      ins(1'b0, 3'b000, 16'h0, 5'b0, 3'd0, 3'b000, 1'b0, 16'h0, 16'h0);
      step();
      mem_stall = 1'b0; exc_clr = 1'b0;
      chk("stall_clr", 32'(exc_ovf), 32'd0);
      chk("stall_clr_epc", 32'(epc), 32'h22);

      // async reset with exception pending
      ins(1'b1, 3'b001, 16'h8000, 5'b01000, 3'd2, 3'b100, 1'b0, 16'h0, 16'h0030);
      step();
      chk("pre_rst_exc", 32'(exc_ovf), 32'd1);
      ins(1'b0, 3'b000, 16'h0, 5'b0, 3'd0, 3'b000, 1'b0, 16'h0, 16'h0);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_exc", 32'({exc_ovf, epc}), 32'd0);
      chk("async_rst_valid", 32'(mem_valid), 32'd0);
      chk("async_rst_flags", 32'(status_flags), 32'd0);
      #1 rst_n = 1'b1;
      step();

      // async reset with branch pulse high
      ins(1'b1, 3'b101, 16'h0001, 5'b00000, 3'd1, 3'b000, 1'b1, 16'h0050, 16'h0034);
      step();
      chk("pre_rst_br", 32'(br_taken), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_br", 32'({br_taken, br_target}), 32'd0);
      chk("async_rst_valid2", 32'(mem_valid), 32'd0);
      #1 rst_n = 1'b1;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline stage for the 16-bit pipelined datapath. It sits directly downstream of the ALU. It does four things:
- captures the ALU result, the ALU flags and the forwarded control bits;
- resolves branch-not-equal;
- raises a sticky signed-overflow exception;
- drives the EX→EX forwarding bus.

All state advances on one clock edge, with stall and flush control from the hazard unit.

## Interface
Parameters:
- W, 16, datapath width
- RA, 3, register-address width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX holds a real instruction
- ex_opcod  in  3  ALU operation select (000 addu, 001 signed add, 010 and, 011 or, 100 slt, 101 bne, 110/111 unused)
- ex_alu_out  in  W  ALU result
- ex_flags  in  5  {Cout, V, lt, eq, gt} from ALU
- ex_store_data  in  W  rt value for stores
- ex_rd  in  RA  destination register
- ex_ctrl  in  3  {reg_write, mem_read, mem_write}
- ex_branch  in  1  instruction is a branch
- ex_br_target  in  W  computed branch target
- ex_pc  in  W  instruction PC
- mem_stall  in  1  MEM cannot accept; hold stage
- flush  in  1  squash the instruction being captured
- exc_clr  in  1  clear pending overflow exception
- mem_valid  out  1  registered valid
- mem_alu_out  out  W  registered result
- mem_store_data  out  W  registered store data
- mem_rd  out  RA  registered destination
- mem_ctrl  out  3  registered control after gating
- status_flags  out  5  flags of the last captured valid instruction
- br_taken  out  1  one-cycle taken-branch pulse
- br_target  out  W  registered target; valid while br_taken=1
- exc_ovf  out  1  sticky overflow exception
- epc  out  W  PC of the overflowing instruction
- fwd_en  out  1  mem_valid & mem_ctrl[2]
- fwd_rd  out  RA  equals mem_rd
- fwd_data  out  W  equals mem_alu_out

## Operation
- **Capture:** ex_valid=1 and not blocked → mem_valid=1.
  - Blocked means exc_ovf=1 already, or flush=1.
  - A blocked or invalid instruction captures as a bubble: mem_valid=0, mem_ctrl=0.
- **Control gating:** mem_ctrl=0 in these cases:
  - opcode 101 (bne has no writeback or memory access);
  - opcodes 110 and 111 (mem_alu_out=0);
  - overflow trap.
- **Overflow trap:** ex_valid & opcode 001 & V=1 & not blocked. Effects:
  - exc_ovf←1 and epc←ex_pc;
  - the instruction still captures with mem_valid=1, but with mem_ctrl=0.
  - Opcode 000 with V=1 does not trap.
- **Branch:** ex_valid & ex_branch & opcode 101 & eq=0 & not blocked → br_taken=1 for exactly one cycle, with br_target←ex_br_target.
  - eq=1 → not taken.
- **Flags:** status_flags←ex_flags on every valid, unblocked capture; otherwise held.
- **Forwarding:** combinational from the stage registers; no extra latency.

## Timing
- **Reset:** all outputs 0, including status_flags, epc and br_target. Reset is asynchronous and effective mid-operation.
- **Latency:** one cycle, EX inputs to MEM outputs.
- **mem_stall=1:** every register holds. br_taken is forced 0 while stalled, so a pulse never repeats.
- **Priority:** flush > mem_stall. With flush=1 and mem_stall=1, the edge loads a bubble.
- **flush** suppresses any branch or trap that would otherwise be captured that cycle.
- **exc_clr** clears exc_ovf on the next edge. The first capture it unblocks is the instruction presented on the edge after exc_ovf reads 0.
  - If exc_clr and a new trap coincide, the set wins: exc_ovf stays 1 and epc takes the new PC.
- **Stall and exc_clr:** exc_clr is honoured even under mem_stall; the exception path is not stalled.

## Structure
- Shared package ex_mem_pkg holds:
  - opcode constants OP_ADDU, OP_ADDS, OP_AND, OP_OR, OP_SLT, OP_BNE;
  - flag bit indices F_COUT, F_V, F_LT, F_EQ, F_GT;
  - control bit indices C_RW, C_MR, C_MW.
- One sub-module: ex_exc_ctrl, covering the exc_ovf sticky bit, epc register, block generation and set-over-clear priority.
- Stage registers and branch logic stay in the top module.

## Test plan
- addu 0x0003+0x0004, rd=2, ctrl=100 → next cycle mem_valid=1, mem_alu_out=0x0007, fwd_en=1, fwd_rd=2.
- bne with eq=0, target 0x0040 → br_taken high for exactly one cycle, br_target=0x0040, mem_ctrl=000.
- The same bne with eq=1 → br_taken stays 0.
- Signed add 0x7FFF+0x0001, V=1, pc=0x0012 → exc_ovf=1, epc=0x0012, mem_ctrl=000.
  - The next three valid instructions capture as bubbles.
  - Assert exc_clr → the following instruction captures normally.
- mem_stall held 3 cycles while an add is captured → outputs frozen and br_taken=0 throughout.
- mem_stall=1 together with flush=1 → bubble loaded.
- Assert rst_n=0 asynchronously mid-stream with exc_ovf=1 and br_taken=1 → all outputs 0 immediately, without waiting for clk.
